// File: rtl/i8284_ready_ctrl.sv
// Bus-cycle READY sequencer for the 8284: qualifies agent RDY lines, synchronises them,
// and bounds the wait states between ALE and the one-cycle READY completion pulse.
module i8284_ready_ctrl #(
    parameter int W        = 4,
    parameter int MIN_WAIT = 0,
    parameter int MAX_WAIT = 8
) (
    input  logic         CLK_IN,
    input  logic         RESN,
    input  logic         ALE,
    input  logic         RDY1,
    input  logic         AEN1N,
    input  logic         RDY2,
    input  logic         AEN2N,
    input  logic         ASYNCN,
    output logic         READY,
    output logic         TIMEOUT,
    output logic [1:0]   STATE,
    output logic [W-1:0] WAIT_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_T1   = 2'd1,
        ST_T2   = 2'd2,
        ST_TW   = 2'd3
    } state_t;

    localparam logic [W-1:0] MIN_C = W'(MIN_WAIT);
    localparam logic [W-1:0] MAX_C = W'(MAX_WAIT);

    state_t state_r;
    logic   s1_r;
    logic   s2_r;
    logic   rdy_q_s;
    logic   rdy_sync_s;
    logic   min_met_s;
    logic   max_hit_s;

    // Agent arbitration: agent 1 has priority when both are enabled.
    always_comb begin
        rdy_q_s = 1'b0;
        if (!AEN1N) begin
            rdy_q_s = RDY1;
        end else if (!AEN2N) begin
            rdy_q_s = RDY2;
        end else begin
            rdy_q_s = 1'b0;
        end
    end

    // Synchroniser depth select and wait-count limit comparisons.
    always_comb begin
        rdy_sync_s = 1'b0;
        if (ASYNCN) begin
            rdy_sync_s = s1_r;
        end else begin
            rdy_sync_s = s2_r;
        end
        min_met_s = (WAIT_CNT >= MIN_C);
        max_hit_s = (WAIT_CNT == MAX_C);
    end

    // Two-flop RDY synchroniser.
    always_ff @(posedge CLK_IN) begin
        if (!RESN) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= rdy_q_s;
            s2_r <= s1_r;
        end
    end

    // Bus-cycle FSM with registered READY/TIMEOUT/WAIT_CNT.
    always_ff @(posedge CLK_IN) begin
        if (!RESN) begin
            state_r  <= ST_IDLE;
            WAIT_CNT <= {W{1'b0}};
            READY    <= 1'b0;
            TIMEOUT  <= 1'b0;
        end else begin
            READY   <= 1'b0;
            TIMEOUT <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (ALE) begin
                        state_r  <= ST_T1;
                        WAIT_CNT <= {W{1'b0}};
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_T1: begin
                    state_r <= ST_T2;
                end
                ST_T2, ST_TW: begin
                    // Ready beats timeout when both hold at MAX_WAIT.
                    if (min_met_s && rdy_sync_s) begin
                        state_r <= ST_IDLE;
                        READY   <= 1'b1;
                    end else if (max_hit_s) begin
                        state_r <= ST_IDLE;
                        READY   <= 1'b1;
                        TIMEOUT <= 1'b1;
                    end else begin
                        state_r  <= ST_TW;
                        WAIT_CNT <= WAIT_CNT + {{(W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign STATE = state_r;

endmodule

// File: tb/tb_i8284_ready_ctrl.sv
// Self-checking bench for i8284_ready_ctrl: a cycle model feeds a scoreboard queue for two
// instances (MIN_WAIT=0 and MIN_WAIT=2), plus directed latency/count checks per scenario.
module tb_i8284_ready_ctrl;

    localparam int W    = 4;
    localparam int MAXW = 8;

    logic       clk = 1'b0;
    logic       resn, ale, rdy1, aen1n, rdy2, aen2n, asyncn;
    logic       ready_a, timeout_a, ready_b, timeout_b;
    logic [1:0] state_a, state_b;
    logic [W-1:0] cnt_a, cnt_b;

    i8284_ready_ctrl #(.W(W), .MIN_WAIT(0), .MAX_WAIT(MAXW)) dut_a (
        .CLK_IN(clk), .RESN(resn), .ALE(ale), .RDY1(rdy1), .AEN1N(aen1n),
        .RDY2(rdy2), .AEN2N(aen2n), .ASYNCN(asyncn),
        .READY(ready_a), .TIMEOUT(timeout_a), .STATE(state_a), .WAIT_CNT(cnt_a)
    );

    i8284_ready_ctrl #(.W(W), .MIN_WAIT(2), .MAX_WAIT(MAXW)) dut_b (
        .CLK_IN(clk), .RESN(resn), .ALE(ale), .RDY1(rdy1), .AEN1N(aen1n),
        .RDY2(rdy2), .AEN2N(aen2n), .ASYNCN(asyncn),
        .READY(ready_b), .TIMEOUT(timeout_b), .STATE(state_b), .WAIT_CNT(cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] state;
        logic [3:0] cnt;
        logic       ready;
        logic       timeout;
        logic       s1;
        logic       s2;
    } mdl_t;

    mdl_t       mdl_a, mdl_b;
    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];
    int         checks = 0;
    int         errors = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic mdl_t mdl_step(input mdl_t m, input int min_w);
        mdl_t n;
        logic rq, rs;
        n  = m;
        rq = !aen1n ? rdy1 : (!aen2n ? rdy2 : 1'b0);
        rs = asyncn ? m.s1 : m.s2;
        n.s1 = rq;
        n.s2 = m.s1;
        n.ready = 1'b0;
        n.timeout = 1'b0;
        if (!resn) begin
            n = '0;
        end else begin
            case (m.state)
                2'd0: if (ale) begin n.state = 2'd1; n.cnt = 4'd0; end
                2'd1: n.state = 2'd2;
                default: begin
                    if (int'(m.cnt) >= min_w && rs) begin
                        n.state = 2'd0; n.ready = 1'b1;
                    end else if (int'(m.cnt) == MAXW) begin
                        n.state = 2'd0; n.ready = 1'b1; n.timeout = 1'b1;
                    end else begin
                        n.state = 2'd3; n.cnt = m.cnt + 4'd1;
                    end
                end
            endcase
        end
        return n;
    endfunction

    task automatic tick();
        mdl_a = mdl_step(mdl_a, 0);
        mdl_b = mdl_step(mdl_b, 2);
        exp_q_a.push_back({mdl_a.state, mdl_a.cnt, mdl_a.ready, mdl_a.timeout});
        exp_q_b.push_back({mdl_b.state, mdl_b.cnt, mdl_b.ready, mdl_b.timeout});
        @(posedge clk);
        #1;
        check_val("cyc_a", {24'd0, state_a, cnt_a, ready_a, timeout_a}, {24'd0, exp_q_a.pop_front()});
        check_val("cyc_b", {24'd0, state_b, cnt_b, ready_b, timeout_b}, {24'd0, exp_q_b.pop_front()});
    endtask

    // One ALE-started bus cycle; rdy_at >= 0 raises RDY1 just before that edge index.
    task automatic bus_cycle(input string tag, input int rdy_at, input int exp_ea, input int exp_eb,
                             input logic exp_to, input logic [3:0] exp_ca, input logic [3:0] exp_cb);
        int         ea, eb;
        logic       to_a;
        logic [3:0] ca, cb;
        ea = -1; eb = -1; to_a = 1'b0; ca = 4'd0; cb = 4'd0;
        ale = 1'b1;
        for (int e = 0; e < 20 && (ea < 0 || eb < 0); e++) begin
            if (e == rdy_at) rdy1 = 1'b1;
            tick();
            ale = 1'b0;
            if (ready_a && ea < 0) begin ea = e; to_a = timeout_a; ca = cnt_a; end
            if (ready_b && eb < 0) begin eb = e; cb = cnt_b; end
        end
        check_val({tag, "_edge_a"}, ea, exp_ea);
        check_val({tag, "_edge_b"}, eb, exp_eb);
        check_val({tag, "_timeout_a"}, {31'd0, to_a}, {31'd0, exp_to});
        check_val({tag, "_cnt_a"}, {28'd0, ca}, {28'd0, exp_ca});
        check_val({tag, "_cnt_b"}, {28'd0, cb}, {28'd0, exp_cb});
    endtask

    initial begin
        mdl_a = '0; mdl_b = '0;
        resn = 1'b0; ale = 1'b0; rdy1 = 1'b1; aen1n = 1'b0; rdy2 = 1'b0; aen2n = 1'b1;
        asyncn = 1'b1;
        tick();
        check_val("reset_state", {30'd0, state_a}, 32'd0);
        check_val("reset_ready", {31'd0, ready_a}, 32'd0);
        resn = 1'b1;
        tick(); tick();

        // Defaults, agent 1 ready throughout.
        bus_cycle("t1", -1, 2, 4, 1'b0, 4'd0, 4'd2);
        tick();

        // No agent enabled: timeout at MAX_WAIT.
        aen1n = 1'b1; aen2n = 1'b1; rdy1 = 1'b1; rdy2 = 1'b1;
        tick(); tick();
        bus_cycle("t3", -1, 10, 10, 1'b1, 4'd8, 4'd8);
        tick();

        // Two-stage sync; RDY1 rises just before e3 and is seen by the FSM at e5.
        asyncn = 1'b0; aen1n = 1'b0; rdy1 = 1'b0; aen2n = 1'b1;
        tick(); tick(); tick();
        bus_cycle("t4", 3, 5, 5, 1'b0, 4'd3, 4'd3);
        rdy1 = 1'b0;
        tick();

        // Agent 1 wins with RDY1=0, then agent 2 alone completes.
        asyncn = 1'b1; aen1n = 1'b0; rdy1 = 1'b0; aen2n = 1'b0; rdy2 = 1'b1;
        tick(); tick();
        bus_cycle("t5a", -1, 10, 10, 1'b1, 4'd8, 4'd8);
        aen1n = 1'b1;
        tick(); tick();
        bus_cycle("t5b", -1, 2, 4, 1'b0, 4'd0, 4'd2);
        tick();

        // Reset in TW at WAIT_CNT=3, with ALE pulses in T1 and TW ignored.
        aen1n = 1'b1; aen2n = 1'b1;
        ale = 1'b1; tick();
        tick();
        tick(); tick();
        ale = 1'b1; tick(); ale = 1'b0;
        check_val("t6_tw_state", {30'd0, state_a}, 32'd3);
        check_val("t6_tw_cnt", {28'd0, cnt_a}, 32'd3);
        resn = 1'b0; tick(); resn = 1'b1;
        check_val("t6_rst_state", {30'd0, state_a}, 32'd0);
        check_val("t6_rst_cnt", {28'd0, cnt_a}, 32'd0);
        check_val("t6_rst_ready", {31'd0, ready_a}, 32'd0);
        aen1n = 1'b0; rdy1 = 1'b1;
        tick(); tick();
        bus_cycle("t6", -1, 2, 4, 1'b0, 4'd0, 4'd2);

        // ALE held high: accepted again in each READY cycle (back-to-back bus cycles).
        ale = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        ale = 1'b0;
        for (int i = 0; i < 6; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
